// File: rtl/md_pkg.sv
// Shared types and constants for the multiply/divide operand interface.
// Parity-related sizing is selected by MD_PARITY_EN in the consuming modules.
package md_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_WAIT  = 2'd2
  } md_tx_state_t;

  localparam logic MD_OP_MPY = 1'b0;
  localparam logic MD_OP_DIV = 1'b1;

  localparam int unsigned MD_WORD_W = 26;

  // Odd parity bit: set when the word holds an even number of ones.
  function automatic logic md_odd_parity(input logic [MD_WORD_W-1:0] word);
    return ~^word;
  endfunction

endpackage : md_pkg

// File: rtl/md_shift_reg.sv
// Parallel-load, right-shift operand register with zero fill.
// With MD_PARITY_EN an odd-parity bit is captured above the data bits at load.
module md_shift_reg
  import md_pkg::*;
#(
  parameter int unsigned W = MD_WORD_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic [W-1:0] din_i,
  output logic         lsb_o
);

`ifdef MD_PARITY_EN
  localparam int unsigned RW = W + 1;
`else
  localparam int unsigned RW = W;
`endif

  logic [RW-1:0] sr_q;
  logic [RW-1:0] sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load_i) begin
`ifdef MD_PARITY_EN
      // Parity sits in the MSB so it emerges on the slot right after the data.
      sr_d = {~^din_i, din_i};
`else
      sr_d = din_i;
`endif
    end else if (shift_i) begin
      sr_d = {1'b0, sr_q[RW-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign lsb_o = sr_q[0];

endmodule : md_shift_reg

// File: rtl/md_operand_tx.sv
// MD unit operand initiator: serializes two operands LSB first, then awaits md_done.
// Optional odd-parity trailer slot enabled by MD_PARITY_EN.
module md_operand_tx
  import md_pkg::*;
#(
  parameter int unsigned WORD_W  = MD_WORD_W,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_op,
  input  logic [WORD_W-1:0] req_a,
  input  logic [WORD_W-1:0] req_b,
  output logic              dl_a,
  output logic              dl_b,
  output logic              dl_frame,
  output logic              dl_op,
  input  logic              md_done,
  output logic              busy,
  output logic              cmp_done,
  output logic              cmp_err
);

`ifdef MD_PARITY_EN
  localparam int unsigned NB = WORD_W + 1;
`else
  localparam int unsigned NB = WORD_W;
`endif
  localparam int unsigned CNT_W = $clog2(NB + 1);
  localparam int unsigned TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT - 1) : 1;

  md_tx_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             op_q, op_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic load;
  logic shift;
  logic a_lsb;
  logic b_lsb;
  logic div_chk;

  assign div_chk = (req_op == MD_OP_DIV) && (req_a[WORD_W-2:0] == '0);
  assign shift   = (state_q == ST_SHIFT);

  md_shift_reg #(.W(WORD_W)) u_sr_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (load),
    .shift_i (shift),
    .din_i   (req_a),
    .lsb_o   (a_lsb)
  );

  md_shift_reg #(.W(WORD_W)) u_sr_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (load),
    .shift_i (shift),
    .din_i   (req_b),
    .lsb_o   (b_lsb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      tmo_q   <= '0;
      op_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      op_q    <= op_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_d   = '0;
    op_d    = op_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (req_valid) begin
          if (div_chk) begin
            err_d = 1'b1;
          end else begin
            load    = 1'b1;
            op_d    = (req_op == MD_OP_DIV) ? MD_OP_DIV : MD_OP_MPY;
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(NB - 1)) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // The last WAIT cycle is the one where the counter would step to TIMEOUT-1;
        // md_done there still wins over the error.
        if (md_done) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (tmo_q == TMO_W'(TIMEOUT - 2)) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    busy      = 1'b0;
    dl_frame  = 1'b0;
    dl_a      = 1'b0;
    dl_b      = 1'b0;
    unique case (state_q)
      ST_IDLE:  req_ready = 1'b1;
      ST_SHIFT: begin
        busy     = 1'b1;
        dl_frame = 1'b1;
        dl_a     = a_lsb;
        dl_b     = b_lsb;
      end
      ST_WAIT:  busy = 1'b1;
      default:  req_ready = 1'b0;
    endcase
  end

  assign dl_op    = op_q;
  assign cmp_done = done_q;
  assign cmp_err  = err_q;

endmodule : md_operand_tx

// File: tb/tb_md_operand_tx.sv
// Self-checking bench for md_operand_tx: one long-timeout and one TIMEOUT=4 instance
// share stimulus and are checked against a cycle-timeline reference model.
module tb_md_operand_tx;

  localparam int W    = 26;
`ifdef MD_PARITY_EN
  localparam int NB   = W + 1;
`else
  localparam int NB   = W;
`endif
  localparam int TO_M = 64;
  localparam int TO_S = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_op = 1'b0;
  logic         md_done = 1'b0;
  logic [W-1:0] req_a = '0;
  logic [W-1:0] req_b = '0;

  logic rdy_m, busy_m, frm_m, a_m, b_m, op_m, dn_m, er_m;
  logic rdy_s, busy_s, frm_s, a_s, b_s, op_s, dn_s, er_s;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  md_operand_tx #(.WORD_W(W), .TIMEOUT(TO_M)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy_m),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .dl_a(a_m), .dl_b(b_m), .dl_frame(frm_m), .dl_op(op_m),
    .md_done(md_done), .busy(busy_m), .cmp_done(dn_m), .cmp_err(er_m)
  );

  md_operand_tx #(.WORD_W(W), .TIMEOUT(TO_S)) dut_s (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy_s),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .dl_a(a_s), .dl_b(b_s), .dl_frame(frm_s), .dl_op(op_s),
    .md_done(md_done), .busy(busy_s), .cmp_done(dn_s), .cmp_err(er_s)
  );

  function automatic logic [7:0] obs_m();
    return {rdy_m, busy_m, frm_m, a_m, b_m, op_m, dn_m, er_m};
  endfunction

  function automatic logic [7:0] obs_s();
    return {rdy_s, busy_s, frm_s, a_s, b_s, op_s, dn_s, er_s};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Serial slot k: data bit k, or the odd-parity trailer after the data.
  function automatic logic pbit(input logic [W-1:0] v, input int k);
    if (k < W) return v[k];
    return ~^v;
  endfunction

  // Event cycles relative to accept (cycle 0) for a given timeout and md_done offset d into WAIT.
  task automatic txn_times(input int to, input int d, output int donec, output int errc, output int endc);
    if (d >= 0 && d <= to - 2) begin
      donec = NB + 2 + d;
      errc  = -1;
      endc  = donec;
    end else begin
      donec = -1;
      errc  = NB + to;
      endc  = errc;
    end
  endtask

  // Expected {ready,busy,frame,dl_a,dl_b,dl_op,cmp_done,cmp_err} on cycle c.
  function automatic logic [7:0] exp_vec(input int c, input int endc, input int donec, input int errc,
                                         input bit rej, input logic [W-1:0] a, input logic [W-1:0] b,
                                         input bit op);
    logic ready, sh, ea, eb;
    ready = rej || (c >= endc);
    sh    = !rej && (c >= 1) && (c <= NB);
    ea    = sh ? pbit(a, c - 1) : 1'b0;
    eb    = sh ? pbit(b, c - 1) : 1'b0;
    return {ready, !ready, sh, ea, eb, ready ? 1'b0 : op, c == donec, c == errc};
  endfunction

  task automatic run_txn(input bit op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int d, input string tag);
    bit rej;
    int dnm, erm, enm, dns, ers, ens;
    logic [7:0] e, m;
    rej = op && (a[W-2:0] == '0);
    if (rej) begin
      dnm = -1; erm = 1; enm = 1;
      dns = -1; ers = 1; ens = 1;
    end else begin
      txn_times(TO_M, d, dnm, erm, enm);
      txn_times(TO_S, d, dns, ers, ens);
    end
    chk({tag, " accept-ready"}, {6'b0, rdy_m, rdy_s}, 8'b0000_0011);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    md_done   = 1'b0;
    for (int c = 1; c <= enm; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      md_done   = 1'b0;
      if (!rej && c <= NB) begin
        req_valid = ($urandom_range(0, 3) == 0);
        req_op    = 1'($urandom);
        req_a     = W'($urandom);
        req_b     = W'($urandom);
        md_done   = ($urandom_range(0, 5) == 0);
      end
      if (!rej && d >= 0 && d <= TO_M - 2 && c == NB + 1 + d) md_done = 1'b1;
      e = exp_vec(c, enm, dnm, erm, rej, a, b, op);
      m = e[7] ? 8'hFB : 8'hFF;
      chk($sformatf("%s main c=%0d", tag, c), obs_m() & m, e & m);
      e = exp_vec(c, ens, dns, ers, rej, a, b, op);
      m = e[7] ? 8'hFB : 8'hFF;
      chk($sformatf("%s short c=%0d", tag, c), obs_s() & m, e & m);
    end
    req_valid = 1'b0;
    md_done   = 1'b0;
  endtask

  initial begin
    bit op;
    logic [W-1:0] a, b;
    int d;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset main", obs_m(), 8'b1000_0000);
    chk("reset short", obs_s(), 8'b1000_0000);
    rst_n = 1'b1;

    run_txn(1'b0, 26'h0000005, 26'h2000001, 10, "mpy");
    b = W'($urandom);
    run_txn(1'b1, 26'h2000000, b, 5, "divchk");
    a = W'($urandom); b = W'($urandom);
    run_txn(1'b0, a, b, -1, "timeout");
    a = W'($urandom) | 26'h1; b = W'($urandom);
    run_txn(1'b1, a, b, TO_S - 2, "coin_short");
    a = W'($urandom); b = W'($urandom);
    run_txn(1'b0, a, b, TO_M - 2, "coin_main");
    a = W'($urandom); b = W'($urandom);
    run_txn(1'b0, a, b, TO_M - 1, "late_done");
`ifdef MD_PARITY_EN
    b = W'($urandom);
    run_txn(1'b0, 26'h0000003, b, 4, "parity");
`endif

    // Reset during SHIFT, then an immediate fresh request.
    req_valid = 1'b1;
    req_op    = 1'b1;
    req_a     = W'($urandom) | 26'h1;
    req_b     = W'($urandom);
    a = req_a; b = req_b;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      chk($sformatf("prerst c=%0d", c), obs_m(), exp_vec(c, 1000, -1, -1, 1'b0, a, b, 1'b1));
    end
    rst_n = 1'b0;
    #1;
    chk("rst-async main", obs_m(), 8'b1000_0000);
    chk("rst-async short", obs_s(), 8'b1000_0000);
    repeat (2) begin
      @(negedge clk);
      chk("rst-hold main", obs_m(), 8'b1000_0000);
      chk("rst-hold short", obs_s(), 8'b1000_0000);
    end
    rst_n = 1'b1;
    a = W'($urandom); b = W'($urandom);
    run_txn(1'b0, a, b, 3, "postrst");

    for (int i = 0; i < 30; i++) begin
      op = 1'($urandom);
      a  = W'($urandom);
      b  = W'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        op = 1'b1;
        a  = '0;
        a[W-1] = 1'($urandom);
      end
      d = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 70));
      run_txn(op, a, b, d, $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_md_operand_tx
